// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic over x^8+x^4+x^3+x+1 and state types.
package aes_pkg;

    // Reduction term applied when xtime shifts a set bit out of bit 7.
    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_col_t;

    // Multiply by x (0x02) in GF(2^8).
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    // Multiply by one of the fixed MixColumns / InvMixColumns coefficients.
    // Built only from the xtime chain (2a, 4a, 8a) and XORs; with a constant
    // coefficient the case collapses to a small XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] r;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (c)
            8'h02:   r = x2;
            8'h03:   r = x2 ^ a;
            8'h09:   r = x8 ^ a;
            8'h0B:   r = x8 ^ x2 ^ a;
            8'h0D:   r = x8 ^ x4 ^ a;
            8'h0E:   r = x8 ^ x4 ^ x2;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mix_columns_if.sv
// State-in / result-out bus of the MixColumns stage.
// Handshake: a transfer happens on every rising edge where in_valid=1; there is
// no ready, the stage never stalls. out_valid=1 marks a new result_state for
// exactly the cycle after its input was accepted.
interface mix_columns_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       inverse;
    aes_state_t state;
    aes_state_t result_state;
    logic       out_valid;

    modport master (
        output in_valid,
        output inverse,
        output state,
        input  result_state,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  inverse,
        input  state,
        output result_state,
        output out_valid
    );

endinterface

// File: rtl/mix_single_column.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column.
module mix_single_column
    import aes_pkg::*;
(
    input  aes_col_t i_col_in,
    input  logic     i_inverse,
    output aes_col_t o_col_out
);

    logic [7:0] w_a0;
    logic [7:0] w_a1;
    logic [7:0] w_a2;
    logic [7:0] w_a3;
    aes_col_t   w_fwd;
    aes_col_t   w_inv;

    // Row 0 sits in the most significant byte of the column.
    assign w_a0 = i_col_in[31:24];
    assign w_a1 = i_col_in[23:16];
    assign w_a2 = i_col_in[15:8];
    assign w_a3 = i_col_in[7:0];

    // Forward matrix {02,03,01,01} rotated per row, inverse matrix {0e,0b,0d,09}
    // rotated per row; both are evaluated and the mode bit picks one.
    always_comb begin
        w_fwd[31:24] = gf_mul(w_a0, 8'h02) ^ gf_mul(w_a1, 8'h03) ^ w_a2 ^ w_a3;
        w_fwd[23:16] = w_a0 ^ gf_mul(w_a1, 8'h02) ^ gf_mul(w_a2, 8'h03) ^ w_a3;
        w_fwd[15:8]  = w_a0 ^ w_a1 ^ gf_mul(w_a2, 8'h02) ^ gf_mul(w_a3, 8'h03);
        w_fwd[7:0]   = gf_mul(w_a0, 8'h03) ^ w_a1 ^ w_a2 ^ gf_mul(w_a3, 8'h02);

        w_inv[31:24] = gf_mul(w_a0, 8'h0E) ^ gf_mul(w_a1, 8'h0B)
                     ^ gf_mul(w_a2, 8'h0D) ^ gf_mul(w_a3, 8'h09);
        w_inv[23:16] = gf_mul(w_a0, 8'h09) ^ gf_mul(w_a1, 8'h0E)
                     ^ gf_mul(w_a2, 8'h0B) ^ gf_mul(w_a3, 8'h0D);
        w_inv[15:8]  = gf_mul(w_a0, 8'h0D) ^ gf_mul(w_a1, 8'h09)
                     ^ gf_mul(w_a2, 8'h0E) ^ gf_mul(w_a3, 8'h0B);
        w_inv[7:0]   = gf_mul(w_a0, 8'h0B) ^ gf_mul(w_a1, 8'h0D)
                     ^ gf_mul(w_a2, 8'h09) ^ gf_mul(w_a3, 8'h0E);

        o_col_out = i_inverse ? w_inv : w_fwd;
    end

endmodule

// File: rtl/mix_columns.sv
// AES MixColumns / InvMixColumns round stage with a single output register.
// One result per clock, latency 1, no back-pressure.
module mix_columns
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mix_columns_if.slave bus
);

    aes_state_t w_result;
    aes_state_t r_result;
    logic       r_valid;

    // Column c occupies state[127-32c -: 32]; each gets its own column unit.
    for (genvar c = 0; c < 4; c++) begin : g_col
        mix_single_column u_col (
            .i_col_in  (bus.state[127-32*c -: 32]),
            .i_inverse (bus.inverse),
            .o_col_out (w_result[127-32*c -: 32])
        );
    end

    // Output register: reset wins, otherwise capture only qualified inputs so
    // an undriven state bus while idle never reaches the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_result <= w_result;
            end
        end
    end

    assign bus.result_state = r_result;
    assign bus.out_valid    = r_valid;

endmodule

// File: tb/tb_mix_columns.sv
// Directed and model-based checks of the mix_columns stage.
module tb_mix_columns;
    import aes_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mix_columns_if mc_if ();

    mix_columns dut (
        .clk (clk),
        .rst (rst),
        .bus (mc_if.slave)
    );

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q[$];
    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Shift-and-add GF(2^8) multiply, independent of the xtime chain in the RTL.
    function automatic logic [7:0] sw_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            if (a[7]) a = (a << 1) ^ 8'h1B;
            else      a = a << 1;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] sw_mix(input logic [127:0] st, input logic inv);
        logic [7:0]   coef[4];
        logic [7:0]   a[4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (inv) begin
            coef[0] = 8'h0E; coef[1] = 8'h0B; coef[2] = 8'h0D; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = st[127 - 32*c - 8*r -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                // Row r of the circulant matrix: coefficient for a[j] is coef[(j-r) mod 4].
                for (int j = 0; j < 4; j++) acc = acc ^ sw_mul(a[j], coef[(j - r + 4) % 4]);
                res[127 - 32*c - 8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    // ---------------- driver ----------------
    // Apply one input for one edge; a valid input pushes its expected result,
    // and the output is checked #1 after that edge.
    task automatic send(input string tag, input logic v, input logic inv,
                        input logic [127:0] st, input logic [127:0] exp);
        mc_if.in_valid = v;
        mc_if.inverse  = inv;
        mc_if.state    = st;
        if (v) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (v) begin
            if (exp_q.size() == 0) begin
                check({tag, "_queue"}, 128'd1, 128'd0);
            end else begin
                check(tag, mc_if.result_state, exp_q.pop_front());
            end
            check({tag, "_valid"}, {127'd0, mc_if.out_valid}, 128'd1);
        end
    endtask

    // ---------------- stimulus ----------------
    localparam logic [127:0] S1 = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] R1 = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

    logic [31:0]  col_in_tab[6];
    logic [31:0]  col_out_tab[6];
    logic [127:0] st;
    logic [127:0] ex;
    logic [127:0] fwd_res;
    logic [127:0] orig;

    initial begin
        n_checks = 0;
        n_errors = 0;
        col_in_tab[0] = 32'hdb135345; col_out_tab[0] = 32'h8e4da1bc;
        col_in_tab[1] = 32'hf20a225c; col_out_tab[1] = 32'h9fdc589d;
        col_in_tab[2] = 32'h01010101; col_out_tab[2] = 32'h01010101;
        col_in_tab[3] = 32'hc6c6c6c6; col_out_tab[3] = 32'hc6c6c6c6;
        col_in_tab[4] = 32'hd4d4d4d5; col_out_tab[4] = 32'hd5d5d7d6;
        col_in_tab[5] = 32'h2d26314c; col_out_tab[5] = 32'h4d7ebdf8;

        rst            = 1'b1;
        mc_if.in_valid = 1'b0;
        mc_if.inverse  = 1'b0;
        mc_if.state    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", mc_if.result_state, 128'd0);
        check("reset_valid", {127'd0, mc_if.out_valid}, 128'd0);
        rst = 1'b0;

        // Forward FIPS-197 vector.
        send("fwd_fips", 1'b1, 1'b0, S1, R1);

        // Idle with X on the state bus: output holds, valid drops.
        for (int i = 0; i < 2; i++) begin
            send("idle", 1'b0, 1'b0, 'x, '0);
            check("idle_hold", mc_if.result_state, R1);
            check("idle_valid", {127'd0, mc_if.out_valid}, 128'd0);
        end

        // Column vectors, rotated so each lands in every column position.
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < 4; c++) begin
                st[127 - 32*c -: 32] = col_in_tab[(i + c) % 6];
                ex[127 - 32*c -: 32] = col_out_tab[(i + c) % 6];
            end
            send("fwd_cols", 1'b1, 1'b0, st, ex);
            send("inv_cols", 1'b1, 1'b1, ex, st);
        end

        // Inverse FIPS-197 vector and single-column inverse in each position.
        send("inv_fips", 1'b1, 1'b1, R1, S1);
        for (int c = 0; c < 4; c++) begin
            st = '0;
            ex = '0;
            st[127 - 32*c -: 32] = 32'h8e4da1bc;
            ex[127 - 32*c -: 32] = 32'hdb135345;
            send("inv_col", 1'b1, 1'b1, st, ex);
        end

        // All-zero in both modes.
        send("zero_fwd", 1'b1, 1'b0, '0, '0);
        send("zero_inv", 1'b1, 1'b1, '0, '0);

        // Streaming: alternate modes back to back; valid stays high each cycle.
        for (int i = 0; i < 4; i++) begin
            send("stream_fwd", 1'b1, 1'b0, S1, R1);
            send("stream_inv", 1'b1, 1'b1, R1, S1);
        end
        for (int i = 0; i < 8; i++) begin
            st = {$urandom(), $urandom(), $urandom(), $urandom()};
            send("stream_rand", 1'b1, i[0], st, sw_mix(st, i[0]));
        end

        // Reset with a valid input present: reset wins and clears the output.
        rst            = 1'b1;
        mc_if.in_valid = 1'b1;
        mc_if.inverse  = 1'b0;
        mc_if.state    = S1;
        @(posedge clk);
        #1;
        check("rst_result", mc_if.result_state, 128'd0);
        check("rst_valid", {127'd0, mc_if.out_valid}, 128'd0);
        rst = 1'b0;
        send("post_rst", 1'b1, 1'b0, S1, R1);

        // Random round trip against the software model.
        for (int i = 0; i < 12; i++) begin
            orig    = {$urandom(), $urandom(), $urandom(), $urandom()};
            fwd_res = sw_mix(orig, 1'b0);
            send("rt_fwd", 1'b1, 1'b0, orig, fwd_res);
            send("rt_inv", 1'b1, 1'b1, mc_if.result_state, orig);
        end

        mc_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("end_valid", {127'd0, mc_if.out_valid}, 128'd0);
        check("end_queue", 128'(exp_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
